// File: rtl/display_scan.sv
// display_scan: four-digit hex scanner with a prescaled digit select,
// a shadow buffer swapped in at frame boundaries, and leading-zero blanking.
module display_scan #(
   parameter int PRESCALE = 100000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        load,
   input  logic [15:0] data_in,
   input  logic        blank_lz,
   output logic [1:0]  sel,
   output logic [3:0]  nibble,
   output logic        blank,
   output logic        pending,
   output logic        tick,
   output logic        frame
);

   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] count;
   logic [15:0]   display;
   logic [15:0]   shadow;
   logic          adv;
   logic          wrap;
   logic          z0;
   logic          z1;
   logic          z2;
   logic          zrun;

   assign adv  = enable && (count == LAST);
   assign wrap = adv && (sel == 2'd3);

   always_ff @(posedge clk) begin
      if (reset) begin
         count   <= '0;
         sel     <= 2'd0;
         display <= 16'h0000;
         shadow  <= 16'h0000;
         pending <= 1'b0;
         tick    <= 1'b0;
         frame   <= 1'b0;
      end else begin
         tick  <= adv;
         frame <= wrap;
         if (enable) begin
            if (adv) begin
               count <= '0;
               sel   <= sel + 2'd1;
            end else begin
               count <= count + CW'(1);
            end
         end
         if (load) begin
            shadow  <= data_in;
            pending <= 1'b1;
         end
         // A load landing on the wrap bypasses the shadow entirely.
         if (wrap) begin
            if (load) begin
               display <= data_in;
            end else if (pending) begin
               display <= shadow;
            end
            pending <= 1'b0;
         end
      end
   end

   assign z0 = (display[15:12] == 4'h0);
   assign z1 = z0 && (display[11:8] == 4'h0);
   assign z2 = z1 && (display[7:4] == 4'h0);

   always_comb begin
      nibble = 4'h0;
      zrun   = 1'b0;
      unique case (sel)
         2'd0: begin
            nibble = display[15:12];
            zrun   = z0;
         end
         2'd1: begin
            nibble = display[11:8];
            zrun   = z1;
         end
         2'd2: begin
            nibble = display[7:4];
            zrun   = z2;
         end
         2'd3: begin
            nibble = display[3:0];
            zrun   = 1'b0;
         end
      endcase
   end

   assign blank = !enable || (blank_lz && zrun);

endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan: cycle model with a scoreboard queue, directed
// scenarios with fixed expectations, and a stimulus table.
module tb_display_scan;

   localparam int P = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic        load = 1'b0;
   logic [15:0] data_in = 16'h0;
   logic        blank_lz = 1'b0;
   logic [1:0]  sel;
   logic [3:0]  nibble;
   logic        blank;
   logic        pending;
   logic        tick;
   logic        frame;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic [1:0] sel;
      logic [3:0] nibble;
      logic       blank;
      logic       pending;
      logic       tick;
      logic       frame;
   } exp_t;

   typedef struct {
      logic        r;
      logic        e;
      logic        l;
      logic [15:0] d;
      logic        lz;
      int          n;
   } vec_t;

   exp_t q[$];

   int          m_cnt = 0;
   logic [1:0]  m_sel = 2'd0;
   logic [15:0] m_disp = 16'h0;
   logic [15:0] m_shad = 16'h0;
   logic        m_pend = 1'b0;
   logic        m_tick = 1'b0;
   logic        m_frame = 1'b0;

   display_scan #(.PRESCALE(P)) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .load(load),
      .data_in(data_in),
      .blank_lz(blank_lz),
      .sel(sel),
      .nibble(nibble),
      .blank(blank),
      .pending(pending),
      .tick(tick),
      .frame(frame)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act,
                      input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc(input logic r, input logic e, input logic l,
                      input logic [15:0] d, input logic lz);
      exp_t x;
      logic adv;
      logic wrap;
      int sh;
      logic [15:0] up;
      reset = r;
      enable = e;
      load = l;
      data_in = d;
      blank_lz = lz;
      if (r) begin
         m_cnt = 0;
         m_sel = 2'd0;
         m_disp = 16'h0;
         m_shad = 16'h0;
         m_pend = 1'b0;
         m_tick = 1'b0;
         m_frame = 1'b0;
      end else begin
         adv = e && (m_cnt == P - 1);
         wrap = adv && (m_sel == 2'd3);
         if (e) m_cnt = (m_cnt + 1) % P;
         if (adv) m_sel = m_sel + 2'd1;
         if (wrap && l) m_disp = d;
         else if (wrap && m_pend) m_disp = m_shad;
         if (l) m_shad = d;
         m_pend = wrap ? 1'b0 : (l ? 1'b1 : m_pend);
         m_tick = adv;
         m_frame = wrap;
      end
      sh = 4 * (3 - int'(m_sel));
      up = m_disp >> sh;
      x.sel = m_sel;
      x.nibble = up[3:0];
      x.blank = !e || (lz && m_sel != 2'd3 && up == 16'h0);
      x.pending = m_pend;
      x.tick = m_tick;
      x.frame = m_frame;
      q.push_back(x);
      @(posedge clk);
      #1;
      x = q.pop_front();
      chk("scan", {6'd0, sel, nibble, blank, pending, tick, frame},
          {6'd0, x});
   endtask

   task automatic run(input int n, input logic e, input logic lz);
      repeat (n) cyc(1'b0, e, 1'b0, 16'h0, lz);
   endtask

   task automatic wait_frame(input logic lz);
      int n;
      n = 0;
      do begin
         cyc(1'b0, 1'b1, 1'b0, 16'h0, lz);
         n++;
      end while (!frame && n < 40);
      chk("frame_seen", {15'd0, frame}, 16'd1);
   endtask

   task automatic capture(input logic lz, output logic [3:0] bl,
                          output logic [15:0] nb);
      bl = 4'h0;
      nb = 16'h0;
      for (int i = 0; i < 4; i++) begin
         bl = {bl[2:0], blank};
         nb = {nb[11:0], nibble};
         if (i < 3) run(4, 1'b1, lz);
      end
   endtask

   vec_t tbl[8];

   initial begin
      logic [3:0]  bl;
      logic [15:0] nb;
      logic [7:0]  sq;
      int t;
      int f;
      int bc;

      tbl[0] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1};
      tbl[1] = '{1'b0, 1'b1, 1'b1, 16'h0A05, 1'b1, 7};
      tbl[2] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 20};
      tbl[3] = '{1'b0, 1'b0, 1'b1, 16'h00F0, 1'b1, 5};
      tbl[4] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 30};
      tbl[5] = '{1'b0, 1'b1, 1'b1, 16'h9000, 1'b0, 3};
      tbl[6] = '{1'b1, 1'b1, 1'b1, 16'h1234, 1'b1, 2};
      tbl[7] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 18};

      // Reset state
      cyc(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
      chk("rst_sel", {14'd0, sel}, 16'd0);
      chk("rst_nibble", {12'd0, nibble}, 16'd0);
      chk("rst_blank", {15'd0, blank}, 16'd0);
      chk("rst_pending", {15'd0, pending}, 16'd0);
      chk("rst_tick", {15'd0, tick}, 16'd0);

      // Scan cadence over one frame
      t = 0;
      f = 0;
      sq = 8'h0;
      for (int i = 1; i <= 16; i++) begin
         cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
         t += int'(tick);
         f += int'(frame);
         if (i % 4 == 0) sq = {sq[5:0], sel};
      end
      chk("tick_count", 16'(t), 16'd4);
      chk("frame_count", 16'(f), 16'd1);
      chk("sel_seq", {8'd0, sq}, 16'b01_10_11_00);
      chk("frame_at_wrap", {15'd0, frame}, 16'd1);

      // Mid-frame load waits for the wrap
      run(2, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 16'h12AB, 1'b0);
      chk("pend_set", {15'd0, pending}, 16'd1);
      wait_frame(1'b0);
      chk("pend_clr", {15'd0, pending}, 16'd0);
      capture(1'b0, bl, nb);
      chk("digits_12ab", nb, 16'h12AB);

      // Load coincident with the wrap
      run(3, 1'b1, 1'b1);
      cyc(1'b0, 1'b1, 1'b1, 16'h0007, 1'b1);
      chk("wl_frame", {15'd0, frame}, 16'd1);
      chk("wl_pending", {15'd0, pending}, 16'd0);
      capture(1'b1, bl, nb);
      chk("lz7_blank", {12'd0, bl}, 16'h000E);
      chk("lz7_nibble", {12'd0, nb[3:0]}, 16'h0007);

      // Double load: last wins; all-zero display
      cyc(1'b0, 1'b1, 1'b1, 16'h1111, 1'b1);
      cyc(1'b0, 1'b1, 1'b1, 16'h0000, 1'b1);
      wait_frame(1'b1);
      capture(1'b1, bl, nb);
      chk("lz0_blank", {12'd0, bl}, 16'h000E);
      chk("lz0_digits", nb, 16'h0000);

      // Freeze mid-slot, then resume
      run(2, 1'b1, 1'b0);
      t = 0;
      bc = 0;
      for (int i = 0; i < 10; i++) begin
         cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
         t += int'(tick) + int'(frame);
         bc += int'(blank);
      end
      chk("frz_pulses", 16'(t), 16'd0);
      chk("frz_blank", 16'(bc), 16'd10);
      chk("frz_sel", {14'd0, sel}, 16'd3);
      cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
      chk("res1_sel", {14'd0, sel}, 16'd3);
      chk("res1_tick", {15'd0, tick}, 16'd0);
      cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
      chk("res2_frame", {15'd0, frame}, 16'd1);
      chk("res2_sel", {14'd0, sel}, 16'd0);

      // Reset discards a pending load
      cyc(1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0);
      chk("ff_pend", {15'd0, pending}, 16'd1);
      cyc(1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b0);
      chk("rst2_pend", {15'd0, pending}, 16'd0);
      chk("rst2_sel", {14'd0, sel}, 16'd0);
      wait_frame(1'b0);
      capture(1'b0, bl, nb);
      chk("rst2_digits", nb, 16'h0000);

      // Table-driven segments
      foreach (tbl[k]) begin
         for (int j = 0; j < tbl[k].n; j++)
            cyc(tbl[k].r, tbl[k].e, tbl[k].l && j == 0,
                tbl[k].d, tbl[k].lz);
      end

      // Random traffic
      for (int i = 0; i < 300; i++) begin
         cyc($urandom_range(0, 49) == 0,
             $urandom_range(0, 7) != 0,
             $urandom_range(0, 9) == 0,
             16'($urandom),
             1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/display_scan.md
DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 Parameter: PRESCALE, 100000, enabled clock cycles per digit slot; legal range >= 1.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: enable  input  1  1 = scan runs; 0 = scan frozen and display blanked.
REQ-005 Port: load  input  1  one-cycle strobe requesting capture of data_in.
REQ-006 Port: data_in  input  16  four hex digits; [15:12] is the leftmost digit.
REQ-007 Port: blank_lz  input  1  1 = suppress leading zero digits.
REQ-008 Port: sel  output  2  digit index driving the downstream 2-to-4 one-hot anode decoder.
REQ-009 Port: nibble  output  4  hex value of the digit currently selected.
REQ-010 Port: blank  output  1  1 = current digit must not be lit.
REQ-011 Port: pending  output  1  1 = a load is captured but not yet displayed.
REQ-012 Port: tick  output  1  one-cycle pulse on every digit advance.
REQ-013 Port: frame  output  1  one-cycle pulse when sel wraps from 3 to 0.

Function
REQ-014 The block SHALL have one clock and a synchronous, active-high reset.
REQ-015 Prescaler counter SHALL count 0..PRESCALE-1 on enabled cycles only, with width max(1,$clog2(PRESCALE)).
REQ-016 On an enabled cycle where the counter equals PRESCALE-1, the counter SHALL return to 0 and sel SHALL increment modulo 4 on the same edge.
REQ-017 tick SHALL be registered and high for exactly the cycle after each sel advance.
REQ-018 frame SHALL be registered and high for exactly the cycle after sel advances from 3 to 0, coincident with tick.
REQ-019 With PRESCALE=1, sel SHALL advance on every enabled cycle, and tick SHALL then remain high continuously.
REQ-020 With enable=0, the counter, sel, tick and frame SHALL hold 0-pulse/frozen values: counter and sel hold, tick=0, frame=0.
REQ-021 load=1 SHALL copy data_in into a shadow register and set pending=1 on the next edge, regardless of enable.
REQ-022 A second load while pending=1 SHALL overwrite the shadow register; only the last value is displayed.
REQ-023 On the edge where sel wraps 3->0, if pending=1, the shadow register SHALL transfer to the display register and pending SHALL clear.
REQ-024 If load and the 3->0 wrap occur in the same cycle, data_in SHALL go directly to the display register, and pending SHALL be 0 afterwards.
REQ-025 The display register SHALL change only at frame boundaries; one frame never mixes old and new digits.
REQ-026 sel=0 SHALL map to display[15:12], sel=1 to [11:8], sel=2 to [7:4], and sel=3 to [3:0].
REQ-027 nibble SHALL be combinational from sel and the display register.
REQ-028 blank SHALL be 1 when enable=0.
REQ-029 blank SHALL be 1 when blank_lz=1, sel<3, and the current digit and all digits left of it are zero.
REQ-030 blank SHALL be 0 in all other cases; the digit at sel=3 is never suppressed by blank_lz.

Reset
REQ-031 On reset=1 at an edge, the counter, sel, display register, shadow register, pending, tick and frame SHALL all become 0.
REQ-032 After reset, nibble=0 and blank follows REQ-028..030; with enable=1 and blank_lz=0, blank is 0.
REQ-033 Reset SHALL override load, enable and wrap in the same cycle.
REQ-034 A pending load SHALL be discarded by reset.

Verification (PRESCALE=4)
REQ-035 Reset, then enable=1 -> sel steps 0,1,2,3,0 every 4 cycles; tick pulses every 4 cycles; frame pulses once per 16 cycles.
REQ-036 load data_in=16'h12AB mid-frame -> pending=1 until the 3->0 wrap; nibble then shows 1,2,A,B; pending=0.
REQ-037 load 16'h0007 coincident with the wrap -> pending stays 0; with blank_lz=1, blank=1,1,1,0 and nibble=7 at sel=3.
REQ-038 Display 16'h0000 with blank_lz=1 -> blank=1 for sel 0..2 and blank=0 at sel=3 showing 0.
REQ-039 enable=0 for 10 cycles mid-slot -> sel and counter frozen, blank=1, no tick; on resume, slot completes the remaining count.
REQ-040 load 16'hFFFF, then reset before the wrap -> display stays 16'h0000, pending=0, sel=0.
